tile_scroll_latch: RTL
======================

Name: tile_scroll_latch

Overview:
- Downstream consumer of the shared sub-bus address multiplexer.
- Captures CPU writes strobed by nLATCH0/nLATCH1 on the muxed bus (A, nWE, D) into per-layer scroll/priority shadow registers.
- Commits shadow registers to the active set at vertical blank, so the tilemap generator sees stable values for a whole frame.
- Two latch groups (0 and 1), two layers each: layers 0..3.

Parameters:
- PRI_RESET0, 3'd0, priority reset value of layer 0
- PRI_RESET1, 3'd1, priority reset value of layer 1
- PRI_RESET2, 3'd2, priority reset value of layer 2
- PRI_RESET3, 3'd3, priority reset value of layer 3

Ports:
- CLK_6M  in  1  pixel clock; all logic on its rising edge
- nRST  in  1  synchronous active-low reset
- A  in  13  muxed address bus; only A[2:0] decoded
- D  in  8  CPU write data, valid while the latch strobe is low
- nWE  in  1  muxed write enable, low = write
- nLATCH0  in  1  group 0 strobe, active low (layers 0,1)
- nLATCH1  in  1  group 1 strobe, active low (layers 2,3)
- VBLANK  in  1  vertical blank, high during blank
- SCROLLX0..SCROLLX3  out  9 each  active horizontal scroll per layer
- SCROLLY0..SCROLLY3  out  8 each  active vertical scroll per layer
- PRI0..PRI3  out  3 each  active layer priority
- DIRTY  out  1  shadow differs from active (any write since last commit)

Behaviour:
- Reset (nRST=0 at a clock edge):
  - All shadow and active SCROLLX/SCROLLY = 0.
  - Shadow and active PRIn = PRI_RESETn.
  - DIRTY = 0.
  - Input stage registers: nLATCH0/1 and their delayed copies = 1; VBLANK history = 1. No spurious strobe or commit on reset release.
- Stage 1: register A[2:0], D, nWE, nLATCH0, nLATCH1, VBLANK every cycle.
- Stage 2: hold the previous stage-1 nLATCH0, nLATCH1 and VBLANK.
- Write event, group g: stage1 nLATCHg=0, stage2 nLATCHg=1, stage1 nWE=0.
  - One write per strobe falling edge; strobe held low does not rewrite.
  - Strobe with nWE=1 (read) is ignored.
- Decode, using stage-1 values:
  - Layer = 2*g + A[2].
  - A[1:0]=00: SCROLLX[7:0] <= D.
  - A[1:0]=01: SCROLLX[8] <= D[0]; PRI <= D[3:1]; D[7:4] ignored.
  - A[1:0]=10: SCROLLY <= D.
  - A[1:0]=11: reserved, no write, DIRTY unaffected.
- Latency: strobe falling edge at the input, then 2 CLK_6M edges, then the shadow register is updated.
- Both groups may write in the same cycle; they are independent.
- Commit event: stage1 VBLANK=1, stage2 VBLANK=0 (rising edge).
  - All active registers <= shadow registers.
  - DIRTY <= 0.
- Write and commit in the same cycle:
  - Commit copies the pre-write shadow value.
  - The write lands in the shadow.
  - DIRTY = 1 after that edge.
- DIRTY set on any decoded write, even one writing an identical value.
- Mid-operation reset: pending shadow writes are discarded; all values return to reset values.

Optional Feature:
- Macro: TILE_SCROLL_VBLANK_COMMIT_EN.
- Defined: double-buffered behaviour as above.
- Undefined:
  - No shadow set; decoded writes update the active registers directly at the same latency (2 edges).
  - VBLANK is ignored.
  - DIRTY is tied to 0.
  - Reset values unchanged.

Test Plan:
- Reset release with all strobes high, VBLANK high:
  - All SCROLLX/SCROLLY = 0; PRI0..3 = 0,1,2,3; DIRTY = 0.
  - No change over 100 cycles.
- Group 0, A=0x000 then A=0x001, D=0x34 then D=0x0B, nWE=0; then VBLANK rising:
  - DIRTY=1 after the first write; active outputs unchanged before VBLANK.
  - After commit: SCROLLX0 = 9'h134, PRI0 = 3'd5, DIRTY = 0.
- Group 1, A=0x006, D=0xA5, nWE=0; then commit:
  - SCROLLY3 = 8'hA5; layers 0..2 unchanged.
- Strobe low with nWE=1, and strobe held low for 10 cycles with nWE=0 and D changing mid-pulse:
  - Read: no register change.
  - Held strobe: only the value sampled at the falling edge is stored.
- Write to A[1:0]=11 and simultaneous nLATCH0/nLATCH1 writes:
  - Reserved write: no change, DIRTY stays 0.
  - Simultaneous writes: both layers updated in the same cycle.
- Write whose decode cycle coincides with the VBLANK rising commit, then the next commit:
  - Active outputs hold the old value; DIRTY = 1.
  - New value appears at the next commit.
- Build without TILE_SCROLL_VBLANK_COMMIT_EN:
  - The same write reaches SCROLLX0 two edges after the strobe falling edge, independent of VBLANK.

Source files
------------

// File: rtl/tile_scroll_latch.sv
// Scroll/priority latch for four tilemap layers, fed by the muxed CPU sub-bus.
// Define TILE_SCROLL_VBLANK_COMMIT_EN for shadow registers committed at VBLANK rise.
module tile_scroll_latch #(
  parameter logic [2:0] PRI_RESET0 = 3'd0,
  parameter logic [2:0] PRI_RESET1 = 3'd1,
  parameter logic [2:0] PRI_RESET2 = 3'd2,
  parameter logic [2:0] PRI_RESET3 = 3'd3
) (
  input  logic        CLK_6M,
  input  logic        nRST,
  input  logic [12:0] A,
  input  logic [7:0]  D,
  input  logic        nWE,
  input  logic        nLATCH0,
  input  logic        nLATCH1,
  input  logic        VBLANK,
  output logic [8:0]  SCROLLX0,
  output logic [8:0]  SCROLLX1,
  output logic [8:0]  SCROLLX2,
  output logic [8:0]  SCROLLX3,
  output logic [7:0]  SCROLLY0,
  output logic [7:0]  SCROLLY1,
  output logic [7:0]  SCROLLY2,
  output logic [7:0]  SCROLLY3,
  output logic [2:0]  PRI0,
  output logic [2:0]  PRI1,
  output logic [2:0]  PRI2,
  output logic [2:0]  PRI3,
  output logic        DIRTY
);

  logic [2:0] a1_q;
  logic [7:0] d1_q;
  logic       nwe1_q, nl0_1_q, nl1_1_q, nl0_2_q, nl1_2_q;
  logic [1:0] wr;
  logic       any_wr;
  logic [1:0] lyr;

  // Write target: shadow set when double-buffered, active set otherwise.
  logic [8:0] scx_q [4];
  logic [8:0] scx_d [4];
  logic [7:0] scy_q [4];
  logic [7:0] scy_d [4];
  logic [2:0] pri_q [4];
  logic [2:0] pri_d [4];

  logic [8:0] out_scx [4];
  logic [7:0] out_scy [4];
  logic [2:0] out_pri [4];

  logic unused_a;
  assign unused_a = ^A[12:3];

  always_ff @(posedge CLK_6M) begin
    if (!nRST) begin
      a1_q    <= '0;
      d1_q    <= '0;
      nwe1_q  <= 1'b1;
      nl0_1_q <= 1'b1;
      nl1_1_q <= 1'b1;
      nl0_2_q <= 1'b1;
      nl1_2_q <= 1'b1;
    end else begin
      a1_q    <= A[2:0];
      d1_q    <= D;
      nwe1_q  <= nWE;
      nl0_1_q <= nLATCH0;
      nl1_1_q <= nLATCH1;
      nl0_2_q <= nl0_1_q;
      nl1_2_q <= nl1_1_q;
    end
  end

  // One write per strobe falling edge; reads are ignored.
  assign wr[0] = !nl0_1_q && nl0_2_q && !nwe1_q;
  assign wr[1] = !nl1_1_q && nl1_2_q && !nwe1_q;

  always_comb begin
    scx_d  = scx_q;
    scy_d  = scy_q;
    pri_d  = pri_q;
    any_wr = 1'b0;
    lyr    = '0;
    for (int g = 0; g < 2; g++) begin
      if (wr[g]) begin
        lyr = {g[0], a1_q[2]};
        case (a1_q[1:0])
          2'b00: begin
            scx_d[lyr][7:0] = d1_q;
            any_wr          = 1'b1;
          end
          2'b01: begin
            scx_d[lyr][8] = d1_q[0];
            pri_d[lyr]    = d1_q[3:1];
            any_wr        = 1'b1;
          end
          2'b10: begin
            scy_d[lyr] = d1_q;
            any_wr     = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK_6M) begin
    if (!nRST) begin
      for (int i = 0; i < 4; i++) begin
        scx_q[i] <= '0;
        scy_q[i] <= '0;
      end
      pri_q[0] <= PRI_RESET0;
      pri_q[1] <= PRI_RESET1;
      pri_q[2] <= PRI_RESET2;
      pri_q[3] <= PRI_RESET3;
    end else begin
      scx_q <= scx_d;
      scy_q <= scy_d;
      pri_q <= pri_d;
    end
  end

`ifdef TILE_SCROLL_VBLANK_COMMIT_EN
  logic       vb1_q, vb2_q, commit;
  logic       dirty_q, dirty_d;
  logic [8:0] act_scx_q [4];
  logic [7:0] act_scy_q [4];
  logic [2:0] act_pri_q [4];

  assign commit = vb1_q && !vb2_q;

  // A write coinciding with a commit still leaves the shadow ahead of the active set.
  always_comb begin
    dirty_d = dirty_q;
    if (commit) dirty_d = 1'b0;
    if (any_wr) dirty_d = 1'b1;
  end

  always_ff @(posedge CLK_6M) begin
    if (!nRST) begin
      vb1_q   <= 1'b1;
      vb2_q   <= 1'b1;
      dirty_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        act_scx_q[i] <= '0;
        act_scy_q[i] <= '0;
      end
      act_pri_q[0] <= PRI_RESET0;
      act_pri_q[1] <= PRI_RESET1;
      act_pri_q[2] <= PRI_RESET2;
      act_pri_q[3] <= PRI_RESET3;
    end else begin
      vb1_q   <= VBLANK;
      vb2_q   <= vb1_q;
      dirty_q <= dirty_d;
      if (commit) begin
        act_scx_q <= scx_q;
        act_scy_q <= scy_q;
        act_pri_q <= pri_q;
      end
    end
  end

  assign out_scx = act_scx_q;
  assign out_scy = act_scy_q;
  assign out_pri = act_pri_q;
  assign DIRTY   = dirty_q;
`else
  logic unused_vb;
  assign unused_vb = VBLANK ^ any_wr;

  assign out_scx = scx_q;
  assign out_scy = scy_q;
  assign out_pri = pri_q;
  assign DIRTY   = 1'b0;
`endif

  assign SCROLLX0 = out_scx[0];
  assign SCROLLX1 = out_scx[1];
  assign SCROLLX2 = out_scx[2];
  assign SCROLLX3 = out_scx[3];
  assign SCROLLY0 = out_scy[0];
  assign SCROLLY1 = out_scy[1];
  assign SCROLLY2 = out_scy[2];
  assign SCROLLY3 = out_scy[3];
  assign PRI0     = out_pri[0];
  assign PRI1     = out_pri[1];
  assign PRI2     = out_pri[2];
  assign PRI3     = out_pri[3];

endmodule
